keypad_matrix_scanner: RTL and testbench
========================================

Name: keypad_matrix_scanner

Overview:
- Drives the column lines of a ROWS x COLS push-button matrix, one active-low column at a time.
- Samples and synchronises the row lines, and debounces whole scan frames.
- Emits press/release events on a valid/ready interface to the control FSM, and exposes the debounced key bitmap.
- Sits between the board keypad pins and the application logic. Clock is 50 MHz.

Parameters:
- COLS, 4, number of column drive lines.
- ROWS, 4, number of row sense lines.
- SCAN_DIV, 50_000, clock cycles each column is driven (1 ms at 50 MHz).
- DEBOUNCE_FRAMES, 10, consecutive identical frames required before a new bitmap is accepted. Minimum 1.

Ports:
- clk, input, 1, system clock, 50 MHz.
- rst_n, input, 1, asynchronous active-low reset.
- row_n, input, ROWS, raw active-low row lines from the pins; asynchronous to clk.
- col_n, output, COLS, active-low one-hot column drive.
- key_valid, output, 1, an event is presented.
- key_ready, input, 1, the consumer accepts the event when both key_valid and key_ready are high.
- key_code, output, $clog2(ROWS*COLS), key index = row*COLS + col.
- key_press, output, 1, 1 = press, 0 = release.
- keys_state, output, ROWS*COLS, debounced bitmap; bit index = key_code; 1 = held.

Behaviour:
- Clock and reset: one clock; rst_n asynchronous assert, synchronous release.
- Reset values:
  - col_n all ones.
  - key_valid 0, key_code 0, key_press 0, keys_state 0.
  - Internal: prev_frame 0, stable count 0, reported bitmap 0, column index 0, dwell counter 0.
- Row synchroniser: row_n passes through a 2-flop synchroniser and is inverted to active-high before use.
- Scan:
  - The dwell counter runs 0..SCAN_DIV-1 while col_n drives column c low (col_n[c]=0, all others 1).
  - When the counter equals SCAN_DIV-1, the synchronised rows are captured into frame bits [r*COLS+c].
  - c then advances, wrapping COLS-1 -> 0. Frame period is COLS*SCAN_DIV cycles.
  - The first cycle after reset release drives column 0.
- Debounce, evaluated at the capture of the last column (frame complete):
  - If the frame differs from prev_frame: prev_frame <= frame and count <= 1.
  - Otherwise count increments, saturating at DEBOUNCE_FRAMES.
  - keys_state <= frame when count reaches DEBOUNCE_FRAMES (with DEBOUNCE_FRAMES=1, every frame is accepted).
  - Any bounce restarts the count.
- Event generation:
  - diff = keys_state XOR reported.
  - When key_valid is 0 and diff is non-zero, the lowest set index i is presented on the next cycle: key_code=i, key_press=keys_state[i], key_valid=1.
  - key_code and key_press are frozen while key_valid is 1, even if keys_state changes meanwhile.
  - On handshake: reported[i] <= key_press and key_valid <= 0.
  - key_valid is low for at least one cycle between events.
  - Multiple simultaneous changes are reported lowest index first.
  - A press then release that both complete while an event is pending is reported as the pair, or collapses to nothing if diff clears before selection.
  - Events are never lost for the final state.
- No ghosting suppression or multi-key masking; the diagonal-ghost behaviour of the matrix passes through.
- Reset mid-operation:
  - All state returns to reset values immediately.
  - A pending event is dropped; col_n goes to all ones.

Decomposition:
- keypad_pkg:
  - KEY_W = $clog2(ROWS*COLS) localparam helper function.
  - key_event_t struct {code, press}.
- Sub-module keypad_event_encoder: owns the reported bitmap, find-first-set over diff, and the valid/ready output register.

Test Plan (bench parameters: COLS=ROWS=4, SCAN_DIV=4, DEBOUNCE_FRAMES=3; frame = 16 cycles):
1. Release reset, all row_n=1 -> col_n cycles 1110,1101,1011,0111, 4 cycles each; key_valid never rises; keys_state=0 for 10 frames.
2. Hold row_n[1]=0 during column 2 drive, key_ready=1 -> after the 3rd identical frame keys_state=0x0040. The next cycle gives a single key_valid pulse with code 6, press 1. Releasing gives code 6, press 0 three frames later.
3. Toggle the key-6 contact every frame for 6 frames -> no event, keys_state stays 0. Holding it afterwards gives an event exactly 3 frames later.
4. key_ready=0; press keys 3 and 12 simultaneously -> key_valid held with code 3 and outputs stable. Raise ready -> code 3 accepted, then after a low cycle code 12 press 1.
5. key_ready=0; key 5 pressed and stabilised, then released and stabilised -> code 5 press 1 is held throughout. Raise ready -> press accepted, then code 5 press 0.
6. Assert rst_n mid-frame with key_valid high -> key_valid, keys_state and col_n go to 0/0/1111 asynchronously. After release, scanning restarts at column 0.

Source files
------------

// File: rtl/keypad_matrix_scanner_pkg.sv
// rtl/keypad_matrix_scanner_pkg.sv - shared geometry, key-code width helper and key event type
//
// Purpose : definitions shared by the keypad scanner, its event encoder and its
//           event interface.
// Contents: key_w()     - bits needed to encode a key index for a rows x cols matrix
//           KP_ROWS/KP_COLS - default matrix geometry
//           KEY_W       - key-code width for the default geometry
//           key_event_t - {code, press} event as presented to the consumer
package keypad_pkg;

    function automatic int key_w(input int rows, input int cols);
        return (rows * cols > 1) ? $clog2(rows * cols) : 1;
    endfunction

    localparam int KP_ROWS = 4;
    localparam int KP_COLS = 4;
    localparam int KEY_W   = key_w(KP_ROWS, KP_COLS);

    // The event code is sized from the package geometry, so a scanner built
    // with a different ROWS/COLS needs these defaults changed alongside it.
    typedef struct packed {
        logic [KEY_W-1:0] code;
        logic             press;
    } key_event_t;

endpackage

// File: rtl/keypad_matrix_scanner_if.sv
// rtl/keypad_matrix_scanner_if.sv - valid/ready key event channel
//
// Purpose : carries press/release events from the scanner to the consumer.
// Signals : key_valid - an event is presented
//           key_ready - consumer accepts when key_valid && key_ready
//           key_code  - key index = row*COLS + col
//           key_press - 1 = press, 0 = release
// Modports: master (scanner side), slave (consumer side)
interface keypad_matrix_scanner_if #(
    parameter int KEY_W = 4
) ();

    logic             key_valid;
    logic             key_ready;
    logic [KEY_W-1:0] key_code;
    logic             key_press;

    modport master (
        output key_valid,
        output key_code,
        output key_press,
        input  key_ready
    );

    modport slave (
        input  key_valid,
        input  key_code,
        input  key_press,
        output key_ready
    );

endinterface

// File: rtl/keypad_matrix_scanner_event_encoder.sv
// rtl/keypad_matrix_scanner_event_encoder.sv - turns debounced bitmap changes into valid/ready events
//
// Purpose : keeps the bitmap already reported to the consumer, picks the lowest
//           differing key and holds it on the event channel until accepted.
// Ports   : clk, rst_n   - clock, asynchronous active-low reset
//           keys_state   - debounced key bitmap
//           ev_if        - event channel (master side)
module keypad_event_encoder
    import keypad_pkg::*;
#(
    parameter int NKEYS = KP_ROWS * KP_COLS
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [NKEYS-1:0] keys_state,
    keypad_matrix_scanner_if.master ev_if
);

    logic [NKEYS-1:0] reported_q;
    logic [NKEYS-1:0] reported_d;
    logic             valid_q;
    logic             valid_d;
    key_event_t       ev_q;
    key_event_t       ev_d;

    logic [NKEYS-1:0] diff;
    logic             found;
    logic [KEY_W-1:0] first_idx;

    // Find-first-set: scanning downward leaves the lowest set index last.
    always_comb begin
        diff      = keys_state ^ reported_q;
        found     = 1'b0;
        first_idx = '0;
        for (int i = NKEYS - 1; i >= 0; i--) begin
            if (diff[i]) begin
                found     = 1'b1;
                first_idx = KEY_W'(i);
            end
        end
    end

    // Selection only happens while idle, so a presented event stays frozen and
    // key_valid always drops for a cycle after each handshake. The reported
    // bitmap is updated with what was actually delivered, so a key that
    // changed again while pending is picked up as a fresh difference.
    always_comb begin
        reported_d = reported_q;
        valid_d    = valid_q;
        ev_d       = ev_q;
        if (valid_q) begin
            if (ev_if.key_ready) begin
                valid_d                = 1'b0;
                reported_d[ev_q.code]  = ev_q.press;
            end
        end else if (found) begin
            valid_d    = 1'b1;
            ev_d.code  = first_idx;
            ev_d.press = keys_state[first_idx];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            reported_q <= '0;
            valid_q    <= 1'b0;
            ev_q       <= '0;
        end else begin
            reported_q <= reported_d;
            valid_q    <= valid_d;
            ev_q       <= ev_d;
        end
    end

    assign ev_if.key_valid = valid_q;
    assign ev_if.key_code  = ev_q.code;
    assign ev_if.key_press = ev_q.press;

endmodule

// File: rtl/keypad_matrix_scanner.sv
// rtl/keypad_matrix_scanner.sv - column-scanning keypad matrix reader with frame debounce
//
// Purpose : drives one active-low column at a time, samples synchronised rows,
//           debounces whole scan frames and reports key changes as events.
// Ports   : clk        - system clock
//           rst_n      - asynchronous active-low reset
//           row_n      - raw active-low row lines (asynchronous)
//           col_n      - active-low one-hot column drive
//           keys_state - debounced bitmap, bit = row*COLS + col, 1 = held
//           key_if     - press/release event channel (master side)
module keypad_matrix_scanner
    import keypad_pkg::*;
#(
    parameter int COLS            = KP_COLS,
    parameter int ROWS            = KP_ROWS,
    parameter int SCAN_DIV        = 50_000,
    parameter int DEBOUNCE_FRAMES = 10
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [ROWS-1:0]      row_n,
    output logic [COLS-1:0]      col_n,
    keypad_matrix_scanner_if.master key_if,
    output logic [ROWS*COLS-1:0] keys_state
);

    localparam int NKEYS   = ROWS * COLS;
    localparam int DWELL_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int COL_W   = (COLS > 1) ? $clog2(COLS) : 1;
    localparam int CNT_W   = $clog2(DEBOUNCE_FRAMES + 1);

    localparam logic [DWELL_W-1:0] DWELL_LAST = DWELL_W'(SCAN_DIV - 1);
    localparam logic [COL_W-1:0]   COL_LAST   = COL_W'(COLS - 1);
    localparam logic [CNT_W-1:0]   CNT_MAX    = CNT_W'(DEBOUNCE_FRAMES);
    localparam logic [CNT_W-1:0]   CNT_ONE    = CNT_W'(1);

    logic [ROWS-1:0]    row_meta_q,   row_meta_d;
    logic [ROWS-1:0]    row_sync_q,   row_sync_d;
    logic               active_q,     active_d;
    logic [DWELL_W-1:0] dwell_q,      dwell_d;
    logic [COL_W-1:0]   col_q,        col_d;
    logic [NKEYS-1:0]   frame_q,      frame_d;
    logic [NKEYS-1:0]   prev_q,       prev_d;
    logic [CNT_W-1:0]   cnt_q,        cnt_d;
    logic [NKEYS-1:0]   keys_state_q, keys_state_d;

    logic [ROWS-1:0]    rows_act;
    logic               capture;
    logic               frame_done;
    logic [NKEYS-1:0]   frame_cap;
    logic [CNT_W-1:0]   cnt_new;

    // Scan and capture.
    // active_q holds the columns released for the first cycle after reset so
    // column 0 then gets its full SCAN_DIV dwell.
    always_comb begin
        row_meta_d = row_n;
        row_sync_d = row_meta_q;
        rows_act   = ~row_sync_q;

        capture    = active_q && (dwell_q == DWELL_LAST);
        frame_done = capture && (col_q == COL_LAST);

        frame_cap = frame_q;
        for (int r = 0; r < ROWS; r++) begin
            for (int c = 0; c < COLS; c++) begin
                if (col_q == COL_W'(c)) begin
                    frame_cap[r*COLS + c] = rows_act[r];
                end
            end
        end

        active_d = 1'b1;
        dwell_d  = dwell_q;
        col_d    = col_q;
        if (active_q) begin
            if (dwell_q == DWELL_LAST) begin
                dwell_d = '0;
                col_d   = (col_q == COL_LAST) ? '0 : col_q + COL_W'(1);
            end else begin
                dwell_d = dwell_q + DWELL_W'(1);
            end
        end

        frame_d = capture ? frame_cap : frame_q;
    end

    // Frame debounce: any frame that differs from the previous one restarts
    // the count at 1; the bitmap is accepted whenever the count sits at
    // DEBOUNCE_FRAMES (which with DEBOUNCE_FRAMES == 1 is every frame).
    always_comb begin
        prev_d       = prev_q;
        cnt_d        = cnt_q;
        keys_state_d = keys_state_q;
        cnt_new      = (cnt_q == CNT_MAX) ? CNT_MAX : cnt_q + CNT_ONE;
        if (frame_done) begin
            if (frame_cap != prev_q) begin
                prev_d  = frame_cap;
                cnt_new = CNT_ONE;
            end
            cnt_d = cnt_new;
            if (cnt_new == CNT_MAX) begin
                keys_state_d = frame_cap;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row_meta_q   <= '1;
            row_sync_q   <= '1;
            active_q     <= 1'b0;
            dwell_q      <= '0;
            col_q        <= '0;
            frame_q      <= '0;
            prev_q       <= '0;
            cnt_q        <= '0;
            keys_state_q <= '0;
        end else begin
            row_meta_q   <= row_meta_d;
            row_sync_q   <= row_sync_d;
            active_q     <= active_d;
            dwell_q      <= dwell_d;
            col_q        <= col_d;
            frame_q      <= frame_d;
            prev_q       <= prev_d;
            cnt_q        <= cnt_d;
            keys_state_q <= keys_state_d;
        end
    end

    always_comb begin
        col_n = '1;
        for (int c = 0; c < COLS; c++) begin
            if (active_q && (col_q == COL_W'(c))) begin
                col_n[c] = 1'b0;
            end
        end
    end

    assign keys_state = keys_state_q;

    keypad_event_encoder #(
        .NKEYS (NKEYS)
    ) u_event_encoder (
        .clk        (clk),
        .rst_n      (rst_n),
        .keys_state (keys_state_q),
        .ev_if      (key_if)
    );

endmodule

// File: tb/tb_keypad_matrix_scanner.sv
// tb/tb_keypad_matrix_scanner.sv - directed self-checking bench for keypad_matrix_scanner
module tb_keypad_matrix_scanner;
    import keypad_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  row_n;
    logic [3:0]  col_n;
    logic [15:0] keys_state;
    logic [15:0] held;
    logic        valid_seen;
    logic [15:0] state_seen;
    logic [3:0]  one_hot;
    logic [3:0]  exp_col;
    int          n_checks = 0;
    int          n_fail   = 0;

    keypad_matrix_scanner_if #(.KEY_W(KEY_W)) key_if ();

    keypad_matrix_scanner #(
        .COLS            (4),
        .ROWS            (4),
        .SCAN_DIV        (4),
        .DEBOUNCE_FRAMES (3)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .row_n      (row_n),
        .col_n      (col_n),
        .key_if     (key_if),
        .keys_state (keys_state)
    );

    always #5 clk = ~clk;

    // Switch matrix: a row is pulled low by any held key in a driven column.
    always_comb begin
        for (int r = 0; r < 4; r++) begin
            row_n[r] = ~|(held[r*4 +: 4] & ~col_n);
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Advance to the first negedge of the next frame (column 0 freshly driven).
    task automatic frame_sync();
        logic [3:0] last;
        logic       hit;
        last = col_n;
        hit  = 1'b0;
        for (int i = 0; i < 40 && !hit; i++) begin
            @(negedge clk);
            valid_seen = valid_seen | key_if.key_valid;
            if (col_n == 4'b1110 && last != 4'b1110) hit = 1'b1;
            last = col_n;
        end
        check("frame_sync", {31'd0, hit}, 32'd1);
    endtask

    function automatic logic [31:0] ev();
        return {26'd0, key_if.key_valid, key_if.key_code, key_if.key_press};
    endfunction

    initial begin
        rst_n            = 1'b0;
        held             = '0;
        key_if.key_ready = 1'b1;
        valid_seen       = 1'b0;
        state_seen       = '0;
        one_hot          = 4'b0001;

        // 1. reset values, column sequence, idle frames
        repeat (3) @(negedge clk);
        check("rst_col_n", {28'd0, col_n}, 32'hF);
        check("rst_event", ev(), 32'd0);
        check("rst_keys_state", {16'd0, keys_state}, 32'd0);
        rst_n = 1'b1;
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            exp_col = ~(one_hot << (k / 4));
            check("scan_col_n", {28'd0, col_n}, {28'd0, exp_col});
        end
        repeat (160) begin
            @(negedge clk);
            valid_seen = valid_seen | key_if.key_valid;
            state_seen = state_seen | keys_state;
        end
        check("idle_no_valid", {31'd0, valid_seen}, 32'd0);
        check("idle_keys_state", {16'd0, state_seen}, 32'd0);

        // 2. key 6 press and release, ready held high
        frame_sync();
        held[6] = 1'b1;
        frame_sync();
        check("k6_f1_state", {16'd0, keys_state}, 32'd0);
        frame_sync();
        check("k6_f2_state", {16'd0, keys_state}, 32'd0);
        frame_sync();
        check("k6_f3_state", {16'd0, keys_state}, 32'h0040);
        check("k6_not_yet_valid", ev(), 32'd0);
        @(negedge clk);
        check("k6_press_ev", ev(), {26'd0, 1'b1, 4'd6, 1'b1});
        @(negedge clk);
        check("k6_single_pulse", {31'd0, key_if.key_valid}, 32'd0);
        frame_sync();
        held[6] = 1'b0;
        frame_sync();
        frame_sync();
        check("k6_rel_f2_state", {16'd0, keys_state}, 32'h0040);
        frame_sync();
        check("k6_rel_f3_state", {16'd0, keys_state}, 32'd0);
        @(negedge clk);
        check("k6_release_ev", ev(), {26'd0, 1'b1, 4'd6, 1'b0});
        @(negedge clk);
        check("k6_rel_pulse_end", {31'd0, key_if.key_valid}, 32'd0);

        // 3. bouncing contact never accepted; steady hold accepted 3 frames later
        valid_seen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            frame_sync();
            held[6] = (i % 2 == 0);
        end
        frame_sync();
        held[6] = 1'b1;
        frame_sync();
        frame_sync();
        check("bounce_state", {16'd0, keys_state}, 32'd0);
        check("bounce_no_event", {31'd0, valid_seen}, 32'd0);
        frame_sync();
        check("bounce_hold_state", {16'd0, keys_state}, 32'h0040);
        @(negedge clk);
        check("bounce_hold_ev", ev(), {26'd0, 1'b1, 4'd6, 1'b1});
        frame_sync();
        held[6] = 1'b0;
        repeat (4) frame_sync();
        check("bounce_rel_state", {16'd0, keys_state}, 32'd0);
        check("bounce_rel_idle", {31'd0, key_if.key_valid}, 32'd0);

        // 4. simultaneous keys 3 and 12 with backpressure
        key_if.key_ready = 1'b0;
        frame_sync();
        held[3]  = 1'b1;
        held[12] = 1'b1;
        repeat (3) frame_sync();
        check("multi_state", {16'd0, keys_state}, 32'h1008);
        @(negedge clk);
        check("multi_first_ev", ev(), {26'd0, 1'b1, 4'd3, 1'b1});
        repeat (5) begin
            @(negedge clk);
            check("multi_hold_ev", ev(), {26'd0, 1'b1, 4'd3, 1'b1});
        end
        key_if.key_ready = 1'b1;
        @(negedge clk);
        check("multi_gap", {31'd0, key_if.key_valid}, 32'd0);
        @(negedge clk);
        check("multi_second_ev", ev(), {26'd0, 1'b1, 4'd12, 1'b1});
        @(negedge clk);
        check("multi_second_end", {31'd0, key_if.key_valid}, 32'd0);
        frame_sync();
        held = '0;
        repeat (4) frame_sync();
        check("multi_rel_state", {16'd0, keys_state}, 32'd0);
        check("multi_rel_idle", {31'd0, key_if.key_valid}, 32'd0);

        // 5. press and release both complete while the press is pending
        key_if.key_ready = 1'b0;
        frame_sync();
        held[5] = 1'b1;
        repeat (3) frame_sync();
        check("k5_state", {16'd0, keys_state}, 32'h0020);
        @(negedge clk);
        check("k5_press_ev", ev(), {26'd0, 1'b1, 4'd5, 1'b1});
        frame_sync();
        held[5] = 1'b0;
        repeat (3) frame_sync();
        check("k5_rel_state", {16'd0, keys_state}, 32'd0);
        check("k5_press_frozen", ev(), {26'd0, 1'b1, 4'd5, 1'b1});
        key_if.key_ready = 1'b1;
        @(negedge clk);
        check("k5_gap", {31'd0, key_if.key_valid}, 32'd0);
        @(negedge clk);
        check("k5_release_ev", ev(), {26'd0, 1'b1, 4'd5, 1'b0});
        @(negedge clk);
        check("k5_release_end", {31'd0, key_if.key_valid}, 32'd0);

        // 6. asynchronous reset with an event pending
        key_if.key_ready = 1'b0;
        frame_sync();
        held[0] = 1'b1;
        repeat (3) frame_sync();
        @(negedge clk);
        check("rst_pending_ev", ev(), {26'd0, 1'b1, 4'd0, 1'b1});
        repeat (5) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_valid", {31'd0, key_if.key_valid}, 32'd0);
        check("async_rst_state", {16'd0, keys_state}, 32'd0);
        check("async_rst_col_n", {28'd0, col_n}, 32'hF);
        held = '0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            exp_col = ~(one_hot << (k / 4));
            check("restart_col_n", {28'd0, col_n}, {28'd0, exp_col});
            check("restart_valid", {31'd0, key_if.key_valid}, 32'd0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
